// File: rtl/gpa_fhdo_spi_rx_if.sv
// -----------------------------------------------------------------------------
// gpa_fhdo_spi_rx_if
// SPI bus bundle between an initiator (e.g. gpa_fhdo_iface or a bench) and the
// gpa_fhdo_spi_rx target.
//   spi_clk_i : SPI clock, driven by the initiator
//   ss_i      : select / SYNC, active low, driven by the initiator
//   sdi_i     : MOSI, driven by the initiator
//   sdo_o     : MISO readback, driven by the target
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface gpa_fhdo_spi_rx_if;
   logic spi_clk_i;
   logic ss_i;
   logic sdi_i;
   logic sdo_o;

   modport master (output spi_clk_i, output ss_i, output sdi_i, input sdo_o);
   modport slave  (input spi_clk_i, input ss_i, input sdi_i, output sdo_o);
endinterface

// File: rtl/gpa_fhdo_spi_rx.sv
// -----------------------------------------------------------------------------
// gpa_fhdo_spi_rx
// Oversampling SPI target that receives 24-bit DAC80504-style frames, keeps
// four DAC shadow registers and serves register readback on SDO.
//
// Ports:
//   clk           fabric clock
//   rst_n         asynchronous active-low reset
//   spi           SPI bus (slave modport): spi_clk_i, ss_i, sdi_i in, sdo_o out
//   word_o        last correctly-sized frame
//   word_valid_o  one-clk pulse, word_o updated
//   frame_err_o   one-clk pulse, frame length != FRAME_BITS
//   dac0_o..3_o   DAC channel shadow registers
//   dac_update_o  one-clk pulse per channel written
//   frame_cnt_o   count of valid frames (wraps)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module gpa_fhdo_spi_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BITS  = 24
) (
   input  logic                clk,
   input  logic                rst_n,
   gpa_fhdo_spi_rx_if.slave    spi,
   output logic [23:0]         word_o,
   output logic                word_valid_o,
   output logic                frame_err_o,
   output logic [15:0]         dac0_o,
   output logic [15:0]         dac1_o,
   output logic [15:0]         dac2_o,
   output logic [15:0]         dac3_o,
   output logic [3:0]          dac_update_o,
   output logic [15:0]         frame_cnt_o
);

   localparam logic [1:0] S_WAIT_IDLE = 2'd0;
   localparam logic [1:0] S_IDLE      = 2'd1;
   localparam logic [1:0] S_SHIFT     = 2'd2;
   localparam logic [1:0] S_DONE      = 2'd3;

   localparam logic [4:0] LP_FRAME = 5'(FRAME_BITS);
   localparam logic [7:0] LP_FLUSH = 8'(SYNC_STAGES + 1);

   // ---- input synchronisers ----
   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_ss_sync;
   logic [SYNC_STAGES-1:0] r_sdi_sync;
   logic                   r_clk_d;
   logic                   r_ss_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clk_sync <= '0;
         r_ss_sync  <= '1;
         r_sdi_sync <= '0;
         r_clk_d    <= 1'b0;
         r_ss_d     <= 1'b1;
      end else begin
         r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], spi.spi_clk_i};
         r_ss_sync  <= {r_ss_sync[SYNC_STAGES-2:0],  spi.ss_i};
         r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], spi.sdi_i};
         r_clk_d    <= r_clk_sync[SYNC_STAGES-1];
         r_ss_d     <= r_ss_sync[SYNC_STAGES-1];
      end
   end

   logic w_clk_s, w_ss_s, w_sdi_s;
   logic w_clk_rise, w_clk_fall, w_ss_rise, w_ss_fall;

   assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
   assign w_ss_s     = r_ss_sync[SYNC_STAGES-1];
   // sdi is taken at the same depth as spi_clk so both see identical delay
   assign w_sdi_s    = r_sdi_sync[SYNC_STAGES-1];
   assign w_clk_rise =  w_clk_s & ~r_clk_d;
   assign w_clk_fall = ~w_clk_s &  r_clk_d;
   assign w_ss_rise  =  w_ss_s  & ~r_ss_d;
   assign w_ss_fall  = ~w_ss_s  &  r_ss_d;

   // ---- frame FSM, decode and register file ----
   logic [1:0]  r_state;
   logic [7:0]  r_flush_cnt;
   logic [4:0]  r_bit_cnt;
   logic [23:0] r_shift;
   logic [23:0] r_tx_word;
   logic        r_rd_pend;
   logic        r_sdo;
   logic [23:0] r_word;
   logic        r_word_valid;
   logic        r_frame_err;
   logic [15:0] r_dac [4];
   logic [3:0]  r_dac_upd;
   logic [15:0] r_frame_cnt;

   logic [7:0]  w_cmd;
   logic [1:0]  w_addr;
   logic        w_is_dac;
   logic        w_flushed;

   assign w_cmd     = r_shift[23:16];
   assign w_addr    = r_shift[17:16];
   // address nibble 0x8..0xB selects DAC channel 0..3
   assign w_is_dac  = (r_shift[19:18] == 2'b10);
   // the synchroniser resets to "ss high", so its output only reflects the pin
   // once it has been refilled; otherwise a frame already in progress at reset
   // release would look like a fresh select and be partially captured
   assign w_flushed = (r_flush_cnt == LP_FLUSH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_WAIT_IDLE;
         r_flush_cnt  <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_tx_word    <= '0;
         r_rd_pend    <= 1'b0;
         r_sdo        <= 1'b0;
         r_word       <= '0;
         r_word_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         for (int i = 0; i < 4; i++) r_dac[i] <= '0;
         r_dac_upd    <= '0;
         r_frame_cnt  <= '0;
      end else begin
         r_word_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         r_dac_upd    <= '0;

         case (r_state)
            S_WAIT_IDLE: begin
               if (!w_flushed) r_flush_cnt <= r_flush_cnt + 8'd1;
               else if (w_ss_s) r_state <= S_IDLE;
            end

            S_IDLE: begin
               if (w_ss_fall) begin
                  r_state   <= S_SHIFT;
                  r_bit_cnt <= '0;
                  r_shift   <= '0;
                  r_sdo     <= r_rd_pend ? r_tx_word[23] : 1'b0;
               end
            end

            S_SHIFT: begin
               // a select release outranks a clock edge seen in the same cycle
               if (w_ss_rise) begin
                  r_state <= S_DONE;
               end else if (w_clk_fall) begin
                  r_shift <= {r_shift[22:0], w_sdi_s};
                  if (r_bit_cnt != 5'd31) r_bit_cnt <= r_bit_cnt + 5'd1;
               end else if (w_clk_rise) begin
                  // bit_cnt bits already taken, so the next readback bit is 23-bit_cnt
                  if (r_rd_pend && (r_bit_cnt < 5'd24))
                     r_sdo <= r_tx_word[5'd23 - r_bit_cnt];
                  else
                     r_sdo <= 1'b0;
               end
            end

            S_DONE: begin
               r_state <= S_IDLE;
               r_sdo   <= 1'b0;
               if (r_bit_cnt == LP_FRAME) begin
                  r_word       <= r_shift;
                  r_word_valid <= 1'b1;
                  r_frame_cnt  <= r_frame_cnt + 16'd1;
                  if (w_cmd[7]) begin
                     r_rd_pend <= 1'b1;
                     r_tx_word <= {w_cmd, (w_is_dac ? r_dac[w_addr] : 16'h0000)};
                  end else if (w_is_dac) begin
                     r_dac[w_addr] <= r_shift[15:0];
                     r_dac_upd     <= 4'b0001 << w_addr;
                     r_rd_pend     <= 1'b0;
                  end
               end else begin
                  r_frame_err <= 1'b1;
                  r_rd_pend   <= 1'b0;
               end
            end

            default: r_state <= S_WAIT_IDLE;
         endcase
      end
   end

   assign spi.sdo_o    = r_sdo;
   assign word_o       = r_word;
   assign word_valid_o = r_word_valid;
   assign frame_err_o  = r_frame_err;
   assign dac0_o       = r_dac[0];
   assign dac1_o       = r_dac[1];
   assign dac2_o       = r_dac[2];
   assign dac3_o       = r_dac[3];
   assign dac_update_o = r_dac_upd;
   assign frame_cnt_o  = r_frame_cnt;

endmodule

// File: tb/tb_gpa_fhdo_spi_rx.sv
// -----------------------------------------------------------------------------
// tb_gpa_fhdo_spi_rx
// Scoreboard bench for gpa_fhdo_spi_rx: the stimulus process drives SPI frames
// and queues the hand-computed outcome of each; a monitor pops and compares
// whenever the DUT pulses word_valid_o or frame_err_o.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gpa_fhdo_spi_rx;
   localparam int SS   = 2;
   localparam int HALF = 10;   // spi_clk half period in clk cycles

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] word_o;
   logic        word_valid_o, frame_err_o;
   logic [15:0] dac0_o, dac1_o, dac2_o, dac3_o;
   logic [3:0]  dac_update_o;
   logic [15:0] frame_cnt_o;

   always #5 clk = ~clk;

   gpa_fhdo_spi_rx_if spi_if();

   gpa_fhdo_spi_rx #(.SYNC_STAGES(SS), .FRAME_BITS(24)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .spi          (spi_if),
      .word_o       (word_o),
      .word_valid_o (word_valid_o),
      .frame_err_o  (frame_err_o),
      .dac0_o       (dac0_o),
      .dac1_o       (dac1_o),
      .dac2_o       (dac2_o),
      .dac3_o       (dac3_o),
      .dac_update_o (dac_update_o),
      .frame_cnt_o  (frame_cnt_o)
   );

   typedef struct {
      bit          is_err;
      logic [23:0] word;
      logic [3:0]  upd;
      logic [15:0] cnt;
      logic [63:0] dacs;   // {dac3, dac2, dac1, dac0}
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   ss_rise_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---- monitor ----
   always @(negedge clk) begin
      if (rst_n && (word_valid_o || frame_err_o)) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected no pulse",
                     word_valid_o, frame_err_o);
         end else begin
            mon_e = q.pop_front();
            chk("pulse_err",   frame_err_o,  mon_e.is_err);
            chk("pulse_valid", word_valid_o, !mon_e.is_err);
            chk("word",        word_o,       mon_e.word);
            chk("dac_update",  dac_update_o, mon_e.upd);
            chk("frame_cnt",   frame_cnt_o,  mon_e.cnt);
            chk("dacs",        {dac3_o, dac2_o, dac1_o, dac0_o}, mon_e.dacs);
            chk("latency",     cyc - ss_rise_cyc, SS + 2);
         end
      end else if (rst_n && dac_update_o != 4'b0000) begin
         total++;
         bad++;
         $display("FAIL stray_dac_update: got %0h expected 0 outside word_valid", dac_update_o);
      end
   end

   // ---- stimulus helpers ----
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_ev(input bit err, input logic [23:0] w, input logic [3:0] upd,
                            input logic [15:0] cnt, input logic [15:0] d0, input logic [15:0] d1,
                            input logic [15:0] d2, input logic [15:0] d3);
      exp_t e;
      e.is_err = err;
      e.word   = w;
      e.upd    = upd;
      e.cnt    = cnt;
      e.dacs   = {d3, d2, d1, d0};
      q.push_back(e);
   endtask

   // data changes on spi_clk rise, target samples on fall; sdo checked at each fall
   task automatic shift_bits(input logic [31:0] data, input int nbits,
                             input bit chk_sdo, input logic [23:0] sdo_exp);
      for (int i = nbits - 1; i >= 0; i--) begin
         spi_if.spi_clk_i = 1'b1;
         spi_if.sdi_i     = data[i];
         tick(HALF);
         if (chk_sdo) chk("sdo_bit", spi_if.sdo_o, sdo_exp[i]);
         spi_if.spi_clk_i = 1'b0;
         tick(HALF);
      end
   endtask

   task automatic frame(input logic [31:0] data, input int nbits,
                        input bit chk_sdo, input logic [23:0] sdo_exp);
      spi_if.ss_i = 1'b0;
      tick(HALF);
      shift_bits(data, nbits, chk_sdo, sdo_exp);
      spi_if.ss_i = 1'b1;
      ss_rise_cyc = cyc;
      tick(3 * HALF);
   endtask

   task automatic check_reset_state();
      chk("rst_word",      word_o,       24'h0);
      chk("rst_valid",     word_valid_o, 1'b0);
      chk("rst_err",       frame_err_o,  1'b0);
      chk("rst_dacs",      {dac3_o, dac2_o, dac1_o, dac0_o}, 64'h0);
      chk("rst_dac_upd",   dac_update_o, 4'h0);
      chk("rst_frame_cnt", frame_cnt_o,  16'h0);
      chk("rst_sdo",       spi_if.sdo_o, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test expected finish before 1ms");
      $fatal(1, "watchdog");
   end

   // ---- directed sequence ----
   initial begin
      spi_if.spi_clk_i = 1'b0;
      spi_if.ss_i      = 1'b1;
      spi_if.sdi_i     = 1'b0;
      rst_n = 1'b0;
      tick(5);
      check_reset_state();
      rst_n = 1'b1;
      tick(10);

      // single write to channel 0
      expect_ev(0, 24'h081234, 4'b0001, 16'd1, 16'h1234, 16'h0, 16'h0, 16'h0);
      frame(32'h081234, 24, 0, 24'h0);

      // back-to-back writes to channels 3 and 1
      expect_ev(0, 24'h0BFFFF, 4'b1000, 16'd2, 16'h1234, 16'h0, 16'h0, 16'hFFFF);
      frame(32'h0BFFFF, 24, 0, 24'h0);
      expect_ev(0, 24'h090001, 4'b0010, 16'd3, 16'h1234, 16'h0001, 16'h0, 16'hFFFF);
      frame(32'h090001, 24, 0, 24'h0);

      // short and long frames leave state untouched
      expect_ev(1, 24'h090001, 4'b0000, 16'd3, 16'h1234, 16'h0001, 16'h0, 16'hFFFF);
      frame(32'h7FFFFF, 23, 0, 24'h0);
      expect_ev(1, 24'h090001, 4'b0000, 16'd3, 16'h1234, 16'h0001, 16'h0, 16'hFFFF);
      frame(32'h0123456, 25, 0, 24'h0);

      // write, read back, observe readback on the next frame
      expect_ev(0, 24'h0ABEEF, 4'b0100, 16'd4, 16'h1234, 16'h0001, 16'hBEEF, 16'hFFFF);
      frame(32'h0ABEEF, 24, 0, 24'h0);
      expect_ev(0, 24'h8A0000, 4'b0000, 16'd5, 16'h1234, 16'h0001, 16'hBEEF, 16'hFFFF);
      frame(32'h8A0000, 24, 0, 24'h0);
      expect_ev(0, 24'h000000, 4'b0000, 16'd6, 16'h1234, 16'h0001, 16'hBEEF, 16'hFFFF);
      frame(32'h000000, 24, 1, 24'h8ABEEF);

      // read of a non-DAC address returns zero data; a write clears the pending read
      expect_ev(0, 24'h830000, 4'b0000, 16'd7, 16'h1234, 16'h0001, 16'hBEEF, 16'hFFFF);
      frame(32'h830000, 24, 0, 24'h0);
      expect_ev(0, 24'h0B0000, 4'b1000, 16'd8, 16'h1234, 16'h0001, 16'hBEEF, 16'h0000);
      frame(32'h0B0000, 24, 1, 24'h830000);
      expect_ev(0, 24'h000000, 4'b0000, 16'd9, 16'h1234, 16'h0001, 16'hBEEF, 16'h0000);
      frame(32'h000000, 24, 1, 24'h000000);

      // an errored frame clears the pending read
      expect_ev(0, 24'h8B0000, 4'b0000, 16'd10, 16'h1234, 16'h0001, 16'hBEEF, 16'h0000);
      frame(32'h8B0000, 24, 0, 24'h0);
      expect_ev(1, 24'h8B0000, 4'b0000, 16'd10, 16'h1234, 16'h0001, 16'hBEEF, 16'h0000);
      frame(32'h000000, 23, 0, 24'h0);
      expect_ev(0, 24'h000000, 4'b0000, 16'd11, 16'h1234, 16'h0001, 16'hBEEF, 16'h0000);
      frame(32'h000000, 24, 1, 24'h000000);

      // reset in the middle of a frame, released with ss still low
      spi_if.ss_i = 1'b0;
      tick(HALF);
      shift_bits(32'h081234 >> 14, 10, 0, 24'h0);
      rst_n = 1'b0;
      tick(3);
      check_reset_state();
      rst_n = 1'b1;
      shift_bits(32'h081234 & 32'h3FFF, 14, 0, 24'h0);
      spi_if.ss_i = 1'b1;
      tick(3 * HALF);
      chk("abort_frame_cnt", frame_cnt_o, 16'h0);
      chk("abort_word",      word_o,      24'h0);
      expect_ev(0, 24'h0800AA, 4'b0001, 16'd1, 16'h00AA, 16'h0, 16'h0, 16'h0);
      frame(32'h0800AA, 24, 0, 24'h0);

      // frame counter wrap
      force dut.r_frame_cnt = 16'hFFFF;
      tick(2);
      release dut.r_frame_cnt;
      tick(1);
      chk("cnt_preload", frame_cnt_o, 16'hFFFF);
      expect_ev(0, 24'h090002, 4'b0010, 16'h0000, 16'h00AA, 16'h0002, 16'h0, 16'h0);
      frame(32'h090002, 24, 0, 24'h0);

      tick(20);
      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
